ram_port_arbiter: RTL and testbench

Shares one 32-bit BRAM port between two requesters: a read requester (operand fetch) and a write requester (result write-back, e.g. the matrix answer writer). Each requester uses a valid/ready handshake. The arbiter serialises their accesses with round-robin fairness and drives the BRAM control pins. It sits between the matrix datapath controllers and the BRAM port.

---
 rtl/ram_arb_pkg.sv | 38 +++
 rtl/rr_arb2.sv | 50 +++++
 rtl/ram_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants and types for the BRAM port arbiter:
//               FSM state encoding, requester IDs, bus widths and the
//               word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 32;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        WR_ISSUE = ST_WR_ISSUE,
        RD_ISSUE = ST_RD_ISSUE,
        RD_WAIT  = ST_RD_WAIT,
        ACK      = ST_ACK
    } state_t;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    // BRAM is word addressed in byte units: the two byte-lane bits are forced
    // to zero, everything above is passed through untouched.
    function automatic logic [RAM_ADDR_W-1:0] word_align(input logic [RAM_ADDR_W-1:0] a);
        return a & ~{{(RAM_ADDR_W-2){1'b0}}, 2'b11};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin picker. Holds the last_grant register;
//               on a tie the requester that was not granted last wins.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_req_rd/i_req_wr - request lines
//               i_take            - the current pick is accepted (update history)
//               o_valid           - at least one request pending
//               o_id              - picked requester (REQ_RD / REQ_WR)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_rd,
    input  logic i_req_wr,
    input  logic i_take,
    output logic o_valid,
    output logic o_id
);

    logic r_last_grant;
    logic w_id;

    always_comb begin
        w_id = REQ_RD;
        if (i_req_rd && i_req_wr) begin
            w_id = ~r_last_grant;
        end else if (i_req_wr) begin
            w_id = REQ_WR;
        end
    end

    // Reset to WRITE so the first tie after reset goes to the reader.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_WR;
        end else if (i_take) begin
            r_last_grant <= w_id;
        end
    end

    assign o_valid = i_req_rd | i_req_wr;
    assign o_id    = w_id;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one 32-bit BRAM port between a read requester and a
//               write requester (valid/ready handshakes), round-robin fair,
//               one access in flight at a time.
// Ports       : clk, rst_n                       - clock, async active-low reset
//               i_rd_valid/i_rd_addr             - read request
//               o_rd_ready/o_rd_data             - read done pulse / captured word
//               i_wr_valid/i_wr_addr/_data/_strb - write request
//               o_wr_ready                       - write committed pulse
//               o_busy                           - FSM not in IDLE
//               o_ram_*/i_ram_rd                 - BRAM port pins
// Parameters  : RD_LATENCY - BRAM read latency in cycles, 1..4
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_valid,
    input  logic [RAM_ADDR_W-1:0] i_rd_addr,
    output logic                  o_rd_ready,
    output logic [RAM_DATA_W-1:0] o_rd_data,
    input  logic                  i_wr_valid,
    input  logic [RAM_ADDR_W-1:0] i_wr_addr,
    input  logic [RAM_DATA_W-1:0] i_wr_data,
    input  logic [3:0]            i_wr_strb,
    output logic                  o_wr_ready,
    output logic                  o_busy,
    output logic                  o_ram_clk,
    output logic                  o_ram_rst_p,
    output logic                  o_ram_en,
    output logic [3:0]            o_ram_we,
    output logic [RAM_ADDR_W-1:0] o_ram_addr,
    output logic [RAM_DATA_W-1:0] o_ram_wr,
    input  logic [RAM_DATA_W-1:0] i_ram_rd
);

    localparam logic [1:0] c_WAIT_LOAD = 2'(RD_LATENCY - 1);

    state_t                r_state, w_state_next;
    logic [1:0]            r_wait_cnt, w_wait_cnt_next;
    logic                  r_rd_ready, w_rd_ready_next;
    logic                  r_wr_ready, w_wr_ready_next;
    logic                  r_busy;
    logic                  r_ram_en, w_ram_en_next;
    logic [3:0]            r_ram_we, w_ram_we_next;
    logic [RAM_ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
    logic [RAM_DATA_W-1:0] r_ram_wr, w_ram_wr_next;
    logic [RAM_DATA_W-1:0] r_rd_data, w_rd_data_next;

    logic w_gnt_valid;
    logic w_gnt_id;
    logic w_take;

    // History only advances when IDLE actually hands out the port.
    assign w_take = (r_state == IDLE) && w_gnt_valid;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req_rd (i_rd_valid),
        .i_req_wr (i_wr_valid),
        .i_take   (w_take),
        .o_valid  (w_gnt_valid),
        .o_id     (w_gnt_id)
    );

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_rd_ready_next = 1'b0;
        w_wr_ready_next = 1'b0;
        w_ram_en_next   = r_ram_en;
        w_ram_we_next   = r_ram_we;
        w_ram_addr_next = r_ram_addr;
        w_ram_wr_next   = r_ram_wr;
        w_rd_data_next  = r_rd_data;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_ram_en_next = 1'b1;
                    if (w_gnt_id == REQ_WR) begin
                        w_state_next    = WR_ISSUE;
                        w_ram_we_next   = i_wr_strb;
                        w_ram_addr_next = word_align(i_wr_addr);
                        w_ram_wr_next   = i_wr_data;
                    end else begin
                        w_state_next    = RD_ISSUE;
                        w_ram_we_next   = 4'h0;
                        w_ram_addr_next = word_align(i_rd_addr);
                    end
                end
            end
            WR_ISSUE: begin
                w_ram_en_next   = 1'b0;
                w_ram_we_next   = 4'h0;
                w_wr_ready_next = 1'b1;
                w_state_next    = ACK;
            end
            RD_ISSUE: begin
                w_ram_en_next   = 1'b0;
                w_wait_cnt_next = c_WAIT_LOAD;
                w_state_next    = RD_WAIT;
            end
            RD_WAIT: begin
                if (r_wait_cnt != 2'd0) begin
                    w_wait_cnt_next = r_wait_cnt - 2'd1;
                end else begin
                    w_rd_data_next  = i_ram_rd;
                    w_rd_ready_next = 1'b1;
                    w_state_next    = ACK;
                end
            end
            ACK: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= 2'd0;
            r_rd_ready <= 1'b0;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 4'h0;
            r_ram_addr <= '0;
            r_ram_wr   <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_rd_ready <= w_rd_ready_next;
            r_wr_ready <= w_wr_ready_next;
            r_busy     <= (w_state_next != IDLE);
            r_ram_en   <= w_ram_en_next;
            r_ram_we   <= w_ram_we_next;
            r_ram_addr <= w_ram_addr_next;
            r_ram_wr   <= w_ram_wr_next;
            r_rd_data  <= w_rd_data_next;
        end
    end

    assign o_rd_ready  = r_rd_ready;
    assign o_rd_data   = r_rd_data;
    assign o_wr_ready  = r_wr_ready;
    assign o_busy      = r_busy;
    assign o_ram_clk   = clk;
    assign o_ram_rst_p = ~rst_n;
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wr    = r_ram_wr;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter with behavioural
//               BRAM models (latency 1 and latency 3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- latency-1 instance ----------------
    logic        rd_valid = 1'b0, wr_valid = 1'b0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        o_rd_ready, o_wr_ready, o_busy, o_ram_clk, o_ram_rst_p, o_ram_en;
    logic [31:0] o_rd_data, o_ram_addr, o_ram_wr, ram_rd1;
    logic [3:0]  o_ram_we;

    ram_port_arbiter #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_rd_valid(rd_valid), .i_rd_addr(rd_addr),
        .o_rd_ready(o_rd_ready), .o_rd_data(o_rd_data),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
        .o_wr_ready(o_wr_ready), .o_busy(o_busy),
        .o_ram_clk(o_ram_clk), .o_ram_rst_p(o_ram_rst_p), .o_ram_en(o_ram_en),
        .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_wr(o_ram_wr),
        .i_ram_rd(ram_rd1)
    );

    // ---------------- latency-3 instance (reads only) ----------------
    logic        rd3_valid = 1'b0;
    logic [31:0] rd3_addr = '0;
    logic        rd3_ready, wr3_ready, busy3, ram3_clk, ram3_rst_p, ram3_en;
    logic [31:0] rd3_data, ram3_addr, ram3_wr, ram_rd3;
    logic [3:0]  ram3_we;

    ram_port_arbiter #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_rd_valid(rd3_valid), .i_rd_addr(rd3_addr),
        .o_rd_ready(rd3_ready), .o_rd_data(rd3_data),
        .i_wr_valid(1'b0), .i_wr_addr(32'h0), .i_wr_data(32'h0), .i_wr_strb(4'h0),
        .o_wr_ready(wr3_ready), .o_busy(busy3),
        .o_ram_clk(ram3_clk), .o_ram_rst_p(ram3_rst_p), .o_ram_en(ram3_en),
        .o_ram_we(ram3_we), .o_ram_addr(ram3_addr), .o_ram_wr(ram3_wr),
        .i_ram_rd(ram_rd3)
    );

    // ---------------- BRAM models (read-first, 64 words, aliased) ----------------
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        if (o_ram_en) begin
            pipe1 <= mem1[o_ram_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (o_ram_we[b]) mem1[o_ram_addr[7:2]][8*b +: 8] <= o_ram_wr[8*b +: 8];
        end
    end
    assign ram_rd1 = pipe1;

    always @(posedge clk) begin
        if (ram3_en) pipe3[0] <= mem3[ram3_addr[7:2]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rd3 = pipe3[2];

    // ---------------- checking infrastructure ----------------
    int total = 0;
    int bad   = 0;
    int n_rd_pulse = 0, n_wr_pulse = 0, n_overlap = 0, n_lsb_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (o_rd_ready) n_rd_pulse++;
            if (o_wr_ready) n_wr_pulse++;
            if (o_rd_ready && o_wr_ready) n_overlap++;
            if (o_ram_addr[1:0] != 2'b00) n_lsb_err++;
        end
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];
    logic exp_order [6];
    logic got_order [6];

    initial begin
        int n, p_rd, p_wr, last_c, now_c;
        bit found;

        for (int i = 0; i < 64; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem1[9]  = 32'h12345678;   // 0x24
        mem1[12] = 32'h11223344;   // 0x30
        mem3[9]  = 32'h12345678;

        //            wr    addr          data          strb  exp_addr      exp_rd
        vecs[0] = '{1'b1, 32'h00000010, 32'hDEADBEEF, 4'hF, 32'h00000010, 32'h0};
        vecs[1] = '{1'b0, 32'h00000027, 32'h0,        4'h0, 32'h00000024, 32'h12345678};
        vecs[2] = '{1'b1, 32'h00000033, 32'hAABBCCDD, 4'h5, 32'h00000030, 32'h0};
        vecs[3] = '{1'b0, 32'h00000030, 32'h0,        4'h0, 32'h00000030, 32'h11BB33DD};
        vecs[4] = '{1'b0, 32'h00000012, 32'h0,        4'h0, 32'h00000010, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 32'hFFFFFFFE, 32'h0BADF00D, 4'hF, 32'hFFFFFFFC, 32'h0};
        vecs[6] = '{1'b0, 32'h000000FD, 32'h0,        4'h0, 32'h000000FC, 32'h0BADF00D};
        vecs[7] = '{1'b1, 32'h00000030, 32'h99000000, 4'h8, 32'h00000030, 32'h0};
        vecs[8] = '{1'b0, 32'h00000031, 32'h0,        4'h0, 32'h00000030, 32'h99BB33DD};
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---------------- reset ----------------
        tick(); tick();
        chk("rst_ram_rst_p", {31'h0, o_ram_rst_p}, 32'h1);
        chk("rst_ram_en",    {31'h0, o_ram_en}, 32'h0);
        chk("rst_ram_we",    {28'h0, o_ram_we}, 32'h0);
        chk("rst_ram_addr",  o_ram_addr, 32'h0);
        chk("rst_ram_wr",    o_ram_wr, 32'h0);
        chk("rst_rd_data",   o_rd_data, 32'h0);
        chk("rst_readies",   {30'h0, o_rd_ready, o_wr_ready}, 32'h0);
        chk("rst_busy",      {31'h0, o_busy}, 32'h0);
        rst_n = 1'b1;
        #1 chk("ram_rst_p_released", {31'h0, o_ram_rst_p}, 32'h0);
        chk("ram_clk_follows", {31'h0, o_ram_clk}, {31'h0, clk});
        tick(); tick(); tick();
        chk("idle_ram_en", {31'h0, o_ram_en}, 32'h0);
        chk("idle_busy",   {31'h0, o_busy}, 32'h0);

        // ---------------- contention: R,W,R,W,R,W ----------------
        p_rd = n_rd_pulse; p_wr = n_wr_pulse;
        rd_valid = 1'b1; rd_addr = 32'h24;
        wr_valid = 1'b1; wr_addr = 32'h40; wr_data = 32'h55AA55AA; wr_strb = 4'hF;
        n = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            tick();
            if (o_ram_en) begin
                got_order[n] = (o_ram_we != 4'h0);
                n++;
                if (n == 6) begin
                    rd_valid = 1'b0;
                    wr_valid = 1'b0;
                end
            end
        end
        chk("contention_grants", n, 6);
        rd_valid = 1'b0; wr_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        for (int i = 0; i < n; i++) chk($sformatf("grant_order[%0d]", i), {31'h0, got_order[i]}, {31'h0, exp_order[i]});
        chk("contention_rd_pulses", n_rd_pulse - p_rd, 3);
        chk("contention_wr_pulses", n_wr_pulse - p_wr, 3);
        chk("contention_rd_data",   o_rd_data, 32'h12345678);
        chk("contention_mem_0x40",  mem1[16], 32'h55AA55AA);

        // ---------------- table-driven single transactions ----------------
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].is_wr) begin
                wr_valid = 1'b1; wr_addr = vecs[v].addr; wr_data = vecs[v].data; wr_strb = vecs[v].strb;
            end else begin
                rd_valid = 1'b1; rd_addr = vecs[v].addr;
            end
            tick();   // t+1: issue
            rd_valid = 1'b0; wr_valid = 1'b0;   // dropping valid must not cancel
            chk($sformatf("v%0d_t1_en", v),   {31'h0, o_ram_en}, 32'h1);
            chk($sformatf("v%0d_t1_addr", v), o_ram_addr, vecs[v].exp_addr);
            chk($sformatf("v%0d_t1_we", v),   {28'h0, o_ram_we}, {28'h0, (vecs[v].is_wr ? vecs[v].strb : 4'h0)});
            chk($sformatf("v%0d_t1_busy", v), {31'h0, o_busy}, 32'h1);
            if (vecs[v].is_wr) begin
                chk($sformatf("v%0d_t1_wrdata", v), o_ram_wr, vecs[v].data);
                tick();   // t+2
                chk($sformatf("v%0d_t2_ready", v), {30'h0, o_rd_ready, o_wr_ready}, 32'h1);
                chk($sformatf("v%0d_t2_en_we", v), {27'h0, o_ram_en, o_ram_we}, 32'h0);
                tick();   // t+3
                chk($sformatf("v%0d_t3_idle", v), {29'h0, o_busy, o_rd_ready, o_wr_ready}, 32'h0);
            end else begin
                tick();   // t+2
                chk($sformatf("v%0d_t2_ready", v), {30'h0, o_rd_ready, o_wr_ready}, 32'h0);
                chk($sformatf("v%0d_t2_en", v),    {31'h0, o_ram_en}, 32'h0);
                tick();   // t+3
                chk($sformatf("v%0d_t3_ready", v), {30'h0, o_rd_ready, o_wr_ready}, 32'h2);
                chk($sformatf("v%0d_t3_data", v),  o_rd_data, vecs[v].exp_rd);
                tick();   // t+4
                chk($sformatf("v%0d_t4_idle", v), {29'h0, o_busy, o_rd_ready, o_wr_ready}, 32'h0);
            end
        end

        // ---------------- RD_LATENCY = 3 ----------------
        rd3_valid = 1'b1; rd3_addr = 32'h27;
        tick();
        rd3_valid = 1'b0;
        chk("lat3_t1_addr", ram3_addr, 32'h24);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("lat3_t%0d_ready", k), {31'h0, rd3_ready}, {31'h0, (k == 5)});
        end
        chk("lat3_data", rd3_data, 32'h12345678);

        // ---------------- reset during WR_ISSUE ----------------
        wr_valid = 1'b1; wr_addr = 32'h3C; wr_data = 32'hFEEDFACE; wr_strb = 4'hF;
        tick();
        chk("wrrst_we_before", {28'h0, o_ram_we}, 32'hF);
        rst_n = 1'b0;
        #1;
        chk("wrrst_we_async", {27'h0, o_ram_en, o_ram_we}, 32'h0);
        chk("wrrst_ram_rst_p", {31'h0, o_ram_rst_p}, 32'h1);
        wr_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("wrrst_mem_untouched", mem1[15], 32'h0);

        // ---------------- reset during RD_WAIT ----------------
        rd_valid = 1'b1; rd_addr = 32'h24;
        tick();   // RD_ISSUE
        rd_valid = 1'b0;
        tick();   // RD_WAIT
        p_rd = n_rd_pulse;
        rst_n = 1'b0;
        #1;
        chk("rdrst_rd_data", o_rd_data, 32'h0);
        chk("rdrst_busy",    {31'h0, o_busy}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("rdrst_no_pulse", n_rd_pulse - p_rd, 0);
        chk("rdrst_rd_data_after", o_rd_data, 32'h0);
        wr_valid = 1'b1; wr_addr = 32'h08; wr_data = 32'hCAFEF00D; wr_strb = 4'hF;
        tick();
        wr_valid = 1'b0;
        chk("postrst_t1_en", {31'h0, o_ram_en}, 32'h1);
        tick();
        chk("postrst_t2_wr_ready", {31'h0, o_wr_ready}, 32'h1);
        tick();
        chk("postrst_mem", mem1[2], 32'hCAFEF00D);

        // ---------------- nine-word answer burst ----------------
        wr_valid = 1'b1; wr_addr = 32'h0; wr_data = 32'hA5000000; wr_strb = 4'hF;
        now_c = 0; last_c = 0;
        for (int i = 0; i < 9; i++) begin
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                tick();
                now_c++;
                if (o_wr_ready) found = 1'b1;
            end
            chk($sformatf("burst_pulse[%0d]", i), {31'h0, found}, 32'h1);
            if (i > 0) chk($sformatf("burst_gap[%0d]", i), now_c - last_c, 3);
            last_c = now_c;
            if (i < 8) begin
                wr_addr = 32'((i + 1) * 4);
                wr_data = 32'hA5000000 | 32'(i + 1);
            end else begin
                wr_valid = 1'b0;
            end
        end
        tick(); tick();
        for (int i = 0; i < 9; i++) chk($sformatf("burst_mem[%0d]", i), mem1[i], 32'hA5000000 | 32'(i));

        chk("never_both_ready", n_overlap, 0);
        chk("addr_lsbs_zero",   n_lsb_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
